firebird7_in_gate2_edt_scan_bi_sol_monitor: RTL
===============================================

# firebird7_in_gate2_edt_scan_bi_sol_monitor

Controller that sequences scan-out line (SOL) monitoring during burn-in scan on the gate2 in-test EDT path. It samples the observed scan-out line over a programmed window of shift cycles and counts its toggles. It records sticky rise and fall flags and reports the result on the status bus captured by the SOL status TDR. Start, abort and window length come from the gate2 IJTAG control TDR; all logic runs on the IJTAG clock.

## Interface
Parameters:
- WIN_W, 16, width of window_len and of the internal window counter.
- CNT_W, 15, toggle counter width. Fixed to match the status TDR field; other values are unsupported.

Ports:
- ijtag_tck  in  1  sole clock, rising edge.
- ijtag_reset  in  1  reset, synchronous, active-low.
- mon_start  in  1  level. When 1 in any state, clears the result and starts a new window.
- mon_abort  in  1  level. When 1, returns to IDLE and freezes the result. Has priority over mon_start.
- window_len  in  WIN_W  number of qualified cycles per window. 0 means free-running until abort or start.
- scan_en  in  1  shift qualifier. A sample is qualified only when scan_en=1 in RUN.
- scan_out  in  1  observed scan-out line. Already synchronous to ijtag_tck.
- sol_out  out  1  last qualified sample of scan_out.
- sol_tog_status  out  2  sticky flags. [0] = rising edge seen, [1] = falling edge seen.
- sol_cnt_status  out  CNT_W  toggle count. Saturates at 0x7FFF.
- mon_busy  out  1  1 while in RUN.
- mon_done  out  1  1 while in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Transition priority, evaluated each cycle:
  1. ijtag_reset=0: IDLE, all registers cleared.
  2. mon_abort=1: IDLE, results held.
  3. mon_start=1: RUN with a clear.
  4. Otherwise, state-specific rules below.
- Clear: zero sol_cnt_status, sol_tog_status, sol_out and prev_valid; load win_cnt with window_len. A start in RUN or DONE restarts the window.
- RUN, qualified cycle (scan_en=1):
  - Update sol_out with scan_out.
  - If prev_valid=1 and scan_out differs from sol_out, count one toggle: increment sol_cnt_status, saturating at 0x7FFF (never wraps). Set tog[0] if scan_out=1, otherwise set tog[1].
  - Set prev_valid to 1. The first qualified sample after a clear never counts as a toggle.
  - If window_len was non-zero at start, decrement win_cnt. When a qualified cycle finds win_cnt=1, that sample is processed and the next state is DONE.
- RUN, scan_en=0: no register changes. Toggles on scan_out are ignored.
- Free-running mode (window_len=0 at start): win_cnt is not used; RUN is left only by abort, start or reset.
- window_len is sampled only at a clear. Later changes have no effect on the current window.
- DONE: results held. Stays in DONE until start, abort or reset.
- IDLE: results held from the previous run, or zero after reset.

## Timing
- Reset values: sol_out=0, sol_tog_status=2'b00, sol_cnt_status=0, mon_busy=0, mon_done=0.
- All outputs are registered. There are no combinational input-to-output paths.
- Start: a start in cycle N gives mon_busy=1 and cleared results in cycle N+1. The first qualified sample is at N+1.
- Sample latency: a qualified sample in cycle N is reflected in sol_out, count and flags at N+1.
- Window end: the last qualified sample is in cycle N. At N+1, mon_busy=0, mon_done=1 and final results are visible together.
- Abort: an abort in cycle N gives mon_busy=0 and mon_done=0 at N+1. A qualified sample in cycle N is discarded.
- Abort and start in the same cycle: abort wins, giving IDLE with no clear.
- Reset mid-run: on the next edge, IDLE with all outputs at their reset values.
- Minimum window: window_len=1 gives RUN for one qualified sample, then DONE with count=0.

## Test plan
- Reset: hold ijtag_reset=0 for 2 cycles with random inputs -> all outputs 0 and state IDLE. Pulse mon_start with ijtag_reset=0 -> stays in IDLE.
- Basic window: window_len=8, scan_en=1, scan_out=0,1,0,1,1,0,0,1 -> sol_cnt_status=5, sol_tog_status=2'b11, sol_out=1. mon_done rises one cycle after the 8th sample; mon_busy is high for exactly 8 cycles.
- Qualifier gaps:
  - window_len=4, scan_en=1,0,0,1,1,0,1. scan_out=0 on every qualified cycle; it toggles twice while scan_en=0 -> count=0, flags 2'b00.
  - Same scan_en pattern, scan_out=0,1,1,0 on the qualified cycles -> count=2, flags 2'b11.
- Saturation and abort: window_len=0, scan_out alternating, scan_en=1 for 33000 cycles -> sol_cnt_status=0x7FFF and held there. Then mon_abort=1 -> mon_busy=0 next cycle, count stays 0x7FFF.
- Priority and restart:
  - mon_start and mon_abort together -> IDLE, results unchanged.
  - mon_start during RUN at count=3 -> count=0 next cycle and a new window of the freshly sampled window_len.
- Reset mid-run: ijtag_reset=0 in RUN at count=7 -> next cycle all outputs 0. After release, a start runs normally.

Source files
------------

// File: rtl/firebird7_in_gate2_edt_scan_bi_sol_monitor.sv
// firebird7_in_gate2_edt_scan_bi_sol_monitor: windowed scan-out line toggle monitor for the gate2 EDT burn-in path
module firebird7_in_gate2_edt_scan_bi_sol_monitor #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 15
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             mon_start,
    input  logic             mon_abort,
    input  logic [WIN_W-1:0] window_len,
    input  logic             scan_en,
    input  logic             scan_out,
    output logic             sol_out,
    output logic [1:0]       sol_tog_status,
    output logic [CNT_W-1:0] sol_cnt_status,
    output logic             mon_busy,
    output logic             mon_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state_q, state_d;
    logic             sol_q, sol_d, prev_valid_q, prev_valid_d;
    logic [1:0]       tog_q, tog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             toggle;
    assign toggle = prev_valid_q && (scan_out != sol_q);
    always_comb begin
        state_d      = state_q;
        sol_d        = sol_q;
        prev_valid_d = prev_valid_q;
        tog_d        = tog_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        if (mon_abort) begin
            state_d = IDLE;
        end else if (mon_start) begin
            state_d      = RUN;
            sol_d        = 1'b0;
            prev_valid_d = 1'b0;
            tog_d        = 2'b00;
            cnt_d        = '0;
            win_d        = window_len;
        end else if (state_q == RUN && scan_en) begin
            sol_d        = scan_out;
            prev_valid_d = 1'b1;
            tog_d        = toggle ? (tog_q | (scan_out ? 2'b01 : 2'b10)) : tog_q;
            cnt_d        = (toggle && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
            // win_q==0 only ever means free-running: a finite window leaves RUN at 1
            win_d        = (win_q != '0) ? win_q - 1'b1 : win_q;
            state_d      = (win_q == {{(WIN_W-1){1'b0}}, 1'b1}) ? DONE : RUN;
        end
    end
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            state_q      <= IDLE;
            sol_q        <= 1'b0;
            prev_valid_q <= 1'b0;
            tog_q        <= 2'b00;
            cnt_q        <= '0;
            win_q        <= '0;
        end else begin
            state_q      <= state_d;
            sol_q        <= sol_d;
            prev_valid_q <= prev_valid_d;
            tog_q        <= tog_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
        end
    end
    assign sol_out        = sol_q;
    assign sol_tog_status = tog_q;
    assign sol_cnt_status = cnt_q;
    assign mon_busy       = state_q == RUN;
    assign mon_done       = state_q == DONE;
endmodule
